// File: rtl/fc_ctrl_pkg.sv
// Shared types and defaults for the fully-connected layer control FSM.
package fc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CAL   = 2'b01,
    DRAIN = 2'b10,
    OUT   = 2'b11
  } state_t;

  localparam int CAL_LEN_DEF  = 784;
  localparam int OUT_LEN_DEF  = 10;
  localparam int PIPE_LAT_DEF = 3;

  // Index width for a count of len items, never narrower than one bit.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/fc_ctrl_cnt.sv
// Modulo-LEN beat counter with synchronous clear, enable and terminal-count flag.
module fc_ctrl_cnt
  import fc_ctrl_pkg::*;
#(
  parameter int LEN = 2,
  parameter int W   = idx_width(LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  assign tc = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fc_ctrl_fsm.sv
// Frame controller for a streaming FC layer: accumulate, drain MAC pipeline, emit outputs.
// Optional busy-cycle counter on Perf_Cycles enabled by macro FC_CTRL_PERF_EN.
module fc_ctrl_fsm
  import fc_ctrl_pkg::*;
#(
  parameter int CAL_LEN  = CAL_LEN_DEF,
  parameter int OUT_LEN  = OUT_LEN_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                          S_AXIS_ACLK,
  input  logic                          S_AXIS_ARESET,
  input  logic                          Din_Valid,
  output logic                          Din_Ready,
  output logic                          Cal_Valid,
  output logic                          Mac_Clr,
  output logic [idx_width(CAL_LEN)-1:0] Cal_Idx,
  output logic                          Dout_Valid,
  input  logic                          Dout_Ready,
  output logic                          Dout_Last,
  output logic [idx_width(OUT_LEN)-1:0] Out_Idx,
  output logic                          Busy,
  output logic                          Frame_Done,
  output logic [31:0]                   Perf_Cycles
);

  localparam int CW         = idx_width(CAL_LEN);
  localparam int OW         = idx_width(OUT_LEN);
  localparam int DW         = idx_width(PIPE_LAT);
  localparam int DRAIN_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

  state_t        state, state_next;
  logic          in_fire, out_fire, in_tc, out_tc, drain_done;
  logic [DW-1:0] drain_cnt;

  assign in_fire    = Din_Valid && Din_Ready;
  assign out_fire   = Dout_Valid && Dout_Ready;
  assign drain_done = (drain_cnt == DW'(DRAIN_LAST));

  fc_ctrl_cnt #(.LEN(CAL_LEN), .W(CW)) u_in_cnt (
    .clk (S_AXIS_ACLK),
    .rst (S_AXIS_ARESET),
    .clr (state == IDLE),
    .en  (in_fire),
    .cnt (Cal_Idx),
    .tc  (in_tc)
  );

  fc_ctrl_cnt #(.LEN(OUT_LEN), .W(OW)) u_out_cnt (
    .clk (S_AXIS_ACLK),
    .rst (S_AXIS_ARESET),
    .clr (state == IDLE),
    .en  (out_fire),
    .cnt (Out_Idx),
    .tc  (out_tc)
  );

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_next;
      drain_cnt  <= (state != DRAIN || drain_done) ? '0 : drain_cnt + 1'b1;
      Frame_Done <= (state == OUT) && out_fire && out_tc;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    Din_Ready  = 1'b0;
    Cal_Valid  = 1'b0;
    Mac_Clr    = 1'b0;
    Dout_Valid = 1'b0;
    Dout_Last  = 1'b0;
    Busy       = 1'b1;
    unique case (state)
      IDLE: begin
        Mac_Clr = 1'b1;
        Busy    = 1'b0;
        if (Din_Valid) state_next = CAL;
      end
      CAL: begin
        Din_Ready = 1'b1;
        Cal_Valid = Din_Valid;
        if (Din_Valid && in_tc) state_next = (PIPE_LAT == 0) ? OUT : DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = OUT;
      end
      OUT: begin
        Dout_Valid = 1'b1;
        Dout_Last  = out_tc;
        if (Dout_Ready && out_tc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FC_CTRL_PERF_EN
  // Saturating count of busy cycles; only reset clears it.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      Perf_Cycles <= '0;
    end else if (Busy && (Perf_Cycles != '1)) begin
      Perf_Cycles <= Perf_Cycles + 1'b1;
    end
  end
`else
  assign Perf_Cycles = '0;
`endif

endmodule
